addsub_acc: RTL and testbench
=============================

ADDSUB_ACC -- requirements
Module: addsub_acc

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width in bits, sign-magnitude, MSB = sign.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand beat valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts operand beat.
REQ-006 SHALL have port: in_data  input  WIDTH  operand, sign-magnitude.
REQ-007 SHALL have port: in_sub  input  1  1 = subtract operand from accumulator, 0 = add.
REQ-008 SHALL have port: in_last  input  1  final beat of the packet.
REQ-009 SHALL have port: out_valid  output  1  packet result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: out_sum  output  WIDTH  accumulated result, sign-magnitude.
REQ-012 SHALL have ports: out_cf, out_sf, out_zf  output  1 each  carry/borrow, sign and zero flags of the last operation.
REQ-013 SHALL have port: out_ovf  output  1  sticky overflow over the whole packet.
REQ-014 SHALL have port: out_count  output  8  beats accepted in the packet, saturating at 255.

Function
REQ-015 SHALL implement FSM states IDLE (no beat yet), ACCUM (at least one beat, no last yet) and OUTPUT (result held).
REQ-016 SHALL drive in_ready = 1 in IDLE/ACCUM and 0 in OUTPUT; a beat transfers when in_valid && in_ready.
REQ-017 SHALL, on each transfer, set acc <= acc +/- in_data using sign-magnitude add/sub: convert to two's complement, compute, convert back.
REQ-018 SHALL start every packet with acc = 0; a first beat with in_sub=1 yields the negation of in_data.
REQ-019 SHALL treat negative zero (sign=1, magnitude=0) as +0 on input and never output negative zero.
REQ-020 SHALL, on each transfer, register cf (carry for add, inverted carry-out i.e. borrow for sub), sf = result MSB and zf = (result == 0).
REQ-021 SHALL set ovf when operands share a two's complement sign and the result sign differs; the sum wraps modulo 2^WIDTH.
REQ-022 SHALL OR ovf into out_ovf for every beat of the packet and clear it only when the packet ends.
REQ-023 SHALL increment out_count on each transfer, saturating at 255.
REQ-024 SHALL transition IDLE->ACCUM on a transfer without in_last, and IDLE/ACCUM->OUTPUT on a transfer with in_last.
REQ-025 SHALL assert out_valid in the cycle after the last beat is accepted (1-cycle latency).
REQ-026 SHALL hold out_* stable while out_valid && !out_ready.
REQ-027 SHALL, on out_valid && out_ready, return to IDLE and clear acc, flags and count in the same edge, so in_ready = 1 in the next cycle.
REQ-028 SHALL keep out_sum/flags/count visible (registered values) in IDLE/ACCUM with out_valid = 0.

Reset
REQ-029 SHALL on rst_n low, immediately and irrespective of clk, force state IDLE, acc = 0, out_cf/out_ovf/out_sf/out_zf = 0, out_count = 0 and out_valid = 0; in_ready reads 1.
REQ-030 SHALL discard a partially accumulated packet or an unconsumed result when reset occurs mid-operation.

Structure
REQ-031 SHALL place FSM state encodings (IDLE=2'd0, ACCUM=2'd1, OUTPUT=2'd2) and the count saturation value 255 in the shared package/include.
REQ-032 SHALL instantiate the existing combinational addsub block as its single sub-module (same WIDTH), with the acc register on a and in_data on b.

Verification (WIDTH=8)
REQ-033 SHALL cover: beats 0x05 add, 0x03 add+last -> out_sum 0x08, cf 0, sf 0, zf 0, ovf 0, count 2, out_valid one cycle after the last beat.
REQ-034 SHALL cover: 0x05 add, 0x07 sub+last -> out_sum 0x82 (-2), cf 1, sf 1, zf 0.
REQ-035 SHALL cover: 0x03 add, 0x03 sub+last -> out_sum 0x00, zf 1, cf 0, sf 0.
REQ-036 SHALL cover: 0x64, 0x64, 0x00+last, all add -> out_ovf 1 (sticky), out_sum 0xB8, count 3.
REQ-037 SHALL cover: out_ready held low 3 cycles in OUTPUT -> out_* stable, in_ready 0; out_ready high -> in_ready 1 next cycle, then a new packet starts from acc 0.
REQ-038 SHALL cover: rst_n pulsed low in ACCUM after beat 0x10 -> outputs 0 immediately; next packet 0x01+last -> out_sum 0x01.

Source files
------------

// File: rtl/addsub_acc_pkg.sv
// Shared definitions for the sign-magnitude add/sub accumulator.
package addsub_acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_e;

    localparam logic [7:0] COUNT_MAX = 8'd255;

endpackage

// File: rtl/addsub_acc_addsub.sv
// Combinational sign-magnitude add/sub: converts both operands to two's
// complement, adds or subtracts, and converts the result back.
module addsub_acc_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cf,
    output logic             sf,
    output logic             zf,
    output logic             ovf
);
    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] a_tc, b_tc, r_tc;
    logic [WIDTH:0]   wide;
    logic [M-1:0]     r_mag;

    always_comb begin
        // Negating a zero magnitude gives zero, so negative zero folds to +0.
        a_tc = a[M] ? -{1'b0, a[M-1:0]} : {1'b0, a[M-1:0]};
        b_tc = b[M] ? -{1'b0, b[M-1:0]} : {1'b0, b[M-1:0]};
        if (sub)
            wide = {1'b0, a_tc} + {1'b0, ~b_tc} + {{WIDTH{1'b0}}, 1'b1};
        else
            wide = {1'b0, a_tc} + {1'b0, b_tc};
        r_tc = wide[M:0];
        cf   = sub ? ~wide[WIDTH] : wide[WIDTH];
        sf   = r_tc[M];
        zf   = (r_tc == '0);
        ovf  = sub ? ((a_tc[M] != b_tc[M]) && (r_tc[M] != a_tc[M]))
                   : ((a_tc[M] == b_tc[M]) && (r_tc[M] != a_tc[M]));
        r_mag = r_tc[M] ? -r_tc[M-1:0] : r_tc[M-1:0];
        // The most negative value has no magnitude encoding; it collapses to +0.
        sum = (r_mag == '0) ? '0 : {r_tc[M], r_mag};
    end

endmodule

// File: rtl/addsub_acc.sv
// Packet accumulator: sums sign-magnitude operand beats until in_last, then
// holds the result and flags until the consumer takes it.
module addsub_acc
    import addsub_acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cf,
    output logic             out_sf,
    output logic             out_zf,
    output logic             out_ovf,
    output logic [7:0]       out_count
);
    state_e           state;
    logic [WIDTH-1:0] acc, nxt_sum;
    logic             nxt_cf, nxt_sf, nxt_zf, nxt_ovf;
    logic             xfer;

    addsub_acc_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (acc),
        .b   (in_data),
        .sub (in_sub),
        .sum (nxt_sum),
        .cf  (nxt_cf),
        .sf  (nxt_sf),
        .zf  (nxt_zf),
        .ovf (nxt_ovf)
    );

    assign in_ready  = (state != S_OUTPUT);
    assign out_valid = (state == S_OUTPUT);
    assign out_sum   = acc;
    assign xfer      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            out_cf    <= 1'b0;
            out_sf    <= 1'b0;
            out_zf    <= 1'b0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (xfer) begin
                        acc       <= nxt_sum;
                        out_cf    <= nxt_cf;
                        out_sf    <= nxt_sf;
                        out_zf    <= nxt_zf;
                        out_ovf   <= out_ovf | nxt_ovf;
                        out_count <= (out_count == COUNT_MAX) ? out_count : out_count + 8'd1;
                        state     <= in_last ? S_OUTPUT : S_ACCUM;
                    end
                end
                S_OUTPUT: begin
                    // Handshake retires the packet and readies the next one together.
                    if (out_ready) begin
                        state     <= S_IDLE;
                        acc       <= '0;
                        out_cf    <= 1'b0;
                        out_sf    <= 1'b0;
                        out_zf    <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_count <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_acc.sv
// Bench for addsub_acc: directed packets plus random packets against an
// integer-arithmetic reference model.
module tb_addsub_acc;
    localparam int WIDTH = 8;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready, out_valid, out_cf, out_sf, out_zf, out_ovf;
    logic [WIDTH-1:0] out_sum;
    logic [7:0]       out_count;

    addsub_acc #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cf(out_cf), .out_sf(out_sf), .out_zf(out_zf),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int m_acc, m_cf, m_sf, m_zf, m_ovf, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int sm2int(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic logic [7:0] int2sm(input int v);
        return (v < 0) ? 8'(128 - v) : 8'(v);
    endfunction

    task automatic model_clear();
        m_acc = 0; m_cf = 0; m_sf = 0; m_zf = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] d, input logic s);
        int a, b, raw, ru;
        a   = m_acc;
        b   = sm2int(d);
        raw = s ? a - b : a + b;
        if (raw > 127 || raw < -128) m_ovf = 1;
        m_cf  = s ? int'((a & 255) < (b & 255)) : int'(((a & 255) + (b & 255)) > 255);
        ru    = raw & 255;
        m_sf  = int'(ru >= 128);
        m_zf  = int'(ru == 0);
        m_acc = (ru >= 128) ? ru - 256 : ru;
        if (m_acc == -128) m_acc = 0;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_sum"},   32'(out_sum),   32'(int2sm(m_acc)));
        check({tag, "_cf"},    32'(out_cf),    32'(m_cf));
        check({tag, "_sf"},    32'(out_sf),    32'(m_sf));
        check({tag, "_zf"},    32'(out_zf),    32'(m_zf));
        check({tag, "_ovf"},   32'(out_ovf),   32'(m_ovf));
        check({tag, "_count"}, 32'(out_count), 32'(m_cnt));
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic beat(input logic [7:0] d, input logic s, input logic l);
        check("in_ready_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_step(d, s);
        if (l) begin
            check("out_valid_last", 32'(out_valid), 32'd1);
            check("in_ready_out", 32'(in_ready), 32'd0);
            check_outs("res");
        end else begin
            check("out_valid_mid", 32'(out_valid), 32'd0);
            check_outs("mid");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_outs("idle");
        end
    endtask

    task automatic consume(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check_outs("hold");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_clear();
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
        check_outs("clr");
    endtask

    initial begin
        int nb, gap;
        model_clear();
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check_outs("rst");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        beat(8'h05, 0, 0); beat(8'h03, 0, 1);
        check("p1_sum", 32'(out_sum), 32'h08);
        check("p1_count", 32'(out_count), 32'd2);
        consume(0);

        beat(8'h05, 0, 0); beat(8'h07, 1, 1);
        check("p2_sum", 32'(out_sum), 32'h82);
        check("p2_cf", 32'(out_cf), 32'd1);
        check("p2_sf", 32'(out_sf), 32'd1);
        consume(0);

        beat(8'h03, 0, 0); beat(8'h03, 1, 1);
        check("p3_sum", 32'(out_sum), 32'h00);
        check("p3_zf", 32'(out_zf), 32'd1);
        consume(0);

        beat(8'h64, 0, 0); beat(8'h64, 0, 0); beat(8'h00, 0, 1);
        check("p4_ovf", 32'(out_ovf), 32'd1);
        check("p4_sum", 32'(out_sum), 32'hB8);
        check("p4_count", 32'(out_count), 32'd3);
        consume(0);

        beat(8'h05, 1, 1);
        check("neg_first_sum", 32'(out_sum), 32'h85);
        consume(0);

        beat(8'h80, 1, 1);
        check("negzero_sum", 32'(out_sum), 32'h00);
        check("negzero_zf", 32'(out_zf), 32'd1);
        consume(0);

        beat(8'hFF, 0, 0); beat(8'h01, 1, 1);
        check("min_sum", 32'(out_sum), 32'h00);
        consume(1);

        beat(8'h11, 0, 1);
        consume(3);
        beat(8'h02, 0, 1);
        check("after_stall_sum", 32'(out_sum), 32'h02);
        consume(0);

        beat(8'h10, 0, 0);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check_outs("midrst");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        beat(8'h01, 0, 1);
        check("postrst_sum", 32'(out_sum), 32'h01);
        consume(0);

        for (int i = 0; i < 259; i++) beat(8'($urandom_range(0, 255)), 1'($urandom), 0);
        beat(8'h01, 0, 1);
        check("sat_count", 32'(out_count), 32'd255);
        consume(0);

        for (int p = 0; p < 30; p++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                beat(8'($urandom_range(0, 255)), 1'($urandom), i == nb - 1);
                gap = $urandom_range(0, 2);
                if (i != nb - 1 && gap != 0) idle(gap);
            end
            consume($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
